// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan-state type and segment constants for the 7-segment scan controller.
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, GUARD, SHOW} scan_state_e;
    localparam logic [4:0] BLANK_CODE = 5'd16;
    localparam logic [6:0] SEG_OFF = 7'h7F;
endpackage

// File: rtl/decoder_LCD.sv
// decoder_LCD: hex code to active-low {g,f,e,d,c,b,a} glyph; any code above 15 is dark.
module decoder_LCD
    import seg7_pkg::*;
(
    input  logic [31:0] code,
    output logic [6:0]  seg
);
    always_comb begin
        case (code)
            32'd0:   seg = 7'b1000000;
            32'd1:   seg = 7'b1111001;
            32'd2:   seg = 7'b0100100;
            32'd3:   seg = 7'b0110000;
            32'd4:   seg = 7'b0011001;
            32'd5:   seg = 7'b0010010;
            32'd6:   seg = 7'b0000010;
            32'd7:   seg = 7'b1111000;
            32'd8:   seg = 7'b0000000;
            32'd9:   seg = 7'b0010000;
            32'd10:  seg = 7'b0001000;
            32'd11:  seg = 7'b0000011;
            32'd12:  seg = 7'b1000110;
            32'd13:  seg = 7'b0100001;
            32'd14:  seg = 7'b0000110;
            32'd15:  seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed scan of NDIG common-anode digits with a tear-free shadow value,
// per-slot anode guard interval and optional leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DWELL = 50000,
    parameter int GUARD = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            wr_en_i,
    input  logic [31:0]     wr_data_i,
    input  logic            lzs_i,
    output logic [6:0]      seg_o,
    output logic [NDIG-1:0] an_o,
    output logic            frame_done_o,
    output logic            upd_pending_o
);
    import seg7_pkg::*;

    localparam int CW = $clog2(DWELL);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int DW = 4 * NDIG;
    localparam logic [CW-1:0] CNT_G = CW'(GUARD - 1);
    localparam logic [CW-1:0] CNT_D = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_L = IW'(NDIG - 1);

    scan_state_e   state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [IW-1:0] idx, nidx;
    logic [DW-1:0] shadow, nshadow, pend, rest;
    logic          pending, npending, boundary, slot_end, blank;
    logic [4:0]    code;
    logic [6:0]    glyph;

    // Outputs are built from next-state values so they change on the same edge as the state.
    always_comb begin
        slot_end = state == SHOW && cnt == CNT_D;
        boundary = en_i && slot_end && idx == IDX_L;
        nstate   = !en_i ? IDLE
                 : state == IDLE ? seg7_pkg::GUARD
                 : (state == seg7_pkg::GUARD && cnt == CNT_G) ? SHOW
                 : slot_end ? seg7_pkg::GUARD : state;
        ncnt     = (nstate == IDLE || state == IDLE || slot_end) ? '0 : cnt + 1'b1;
        nidx     = (nstate == IDLE || state == IDLE) ? '0
                 : slot_end ? (idx == IDX_L ? '0 : idx + 1'b1) : idx;
        nshadow  = (boundary && wr_en_i) ? wr_data_i[DW-1:0]
                 : ((boundary || state == IDLE) && pending) ? pend : shadow;
        npending = (boundary && wr_en_i) ? 1'b0
                 : wr_en_i ? 1'b1
                 : (boundary || state == IDLE) ? 1'b0 : pending;
        rest     = nshadow >> {nidx, 2'b00};
        blank    = lzs_i && nidx != '0 && rest == '0;
        code     = blank ? BLANK_CODE : {1'b0, rest[3:0]};
    end

    decoder_LCD u_dec (
        .code (32'(code)),
        .seg  (glyph)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shadow        <= '0;
            pend          <= '0;
            pending       <= 1'b0;
            an_o          <= '1;
            seg_o         <= SEG_OFF;
            frame_done_o  <= 1'b0;
            upd_pending_o <= 1'b0;
        end else begin
            state         <= nstate;
            cnt           <= ncnt;
            idx           <= nidx;
            shadow        <= nshadow;
            pending       <= npending;
            if (wr_en_i) pend <= wr_data_i[DW-1:0];
            an_o          <= nstate == SHOW ? ~(NDIG'(1) << nidx) : '1;
            // The glyph is latched during the guard and held through SHOW so lzs_i changes wait a slot.
            seg_o         <= nstate == IDLE ? SEG_OFF : nstate == seg7_pkg::GUARD ? glyph : seg_o;
            frame_done_o  <= boundary;
            upd_pending_o <= npending;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scan-controller bench against a frame-position reference model.
module tb_seg7_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DWELL = 8;
    localparam int GUARD = 2;
    localparam int F     = NDIG * DWELL;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] wr_data_i = '0;
    logic        lzs_i = 1'b0;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_done_o;
    logic        upd_pending_o;

    seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .lzs_i         (lzs_i),
        .seg_o         (seg_o),
        .an_o          (an_o),
        .frame_done_o  (frame_done_o),
        .upd_pending_o (upd_pending_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    logic [6:0] glyphs [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: position p counts cycles since the scan started; digit and phase follow by division.
    bit         run, pv, e_fd;
    int         p;
    logic [15:0] sh, pd;
    logic [6:0] e_seg;
    logic [3:0] e_an;

    task automatic model_reset();
        run = 0; pv = 0; p = 0; sh = '0; pd = '0;
        e_seg = 7'h7F; e_an = 4'hF; e_fd = 0;
    endtask

    task automatic model_step(input bit en, input bit wr, input bit lzs, input logic [15:0] d);
        bit b;
        int dig, ph;
        logic [15:0] r;
        logic [3:0] nib;
        b = run && en && (p % F == F - 1);
        if (b && wr) begin
            sh = d; pv = 0;
        end else begin
            if ((b || !run) && pv) begin sh = pd; pv = 0; end
            if (wr) begin pd = d; pv = 1; end
        end
        if (!en) run = 0;
        else if (!run) begin run = 1; p = 0; end
        else p = (p + 1) % F;
        e_fd = b;
        if (!run) begin
            e_an = 4'hF; e_seg = 7'h7F;
        end else begin
            dig = p / DWELL;
            ph  = p % DWELL;
            e_an = ph < GUARD ? 4'hF : ~(4'b0001 << dig);
            if (ph < GUARD) begin
                r = sh >> (4 * dig);
                nib = r[3:0];
                e_seg = (lzs && dig > 0 && r == 0) ? 7'h7F : glyphs[nib];
            end
        end
    endtask

    task automatic cyc(input bit en, input bit wr, input bit lzs, input logic [15:0] d);
        en_i = en; wr_en_i = wr; lzs_i = lzs; wr_data_i = {16'h0, d};
        @(posedge clk);
        model_step(en, wr, lzs, d);
        #1;
        check("an", an_o, e_an);
        check("seg", seg_o, e_seg);
        check("frame_done", frame_done_o, e_fd);
        check("upd_pending", upd_pending_o, pv);
    endtask

    task automatic async_reset();
        rst_ni = 1'b0;
        #2;
        model_reset();
        check("rst_an", an_o, 4'hF);
        check("rst_seg", seg_o, 7'h7F);
        check("rst_fd", frame_done_o, 1'b0);
        check("rst_upd", upd_pending_o, 1'b0);
        rst_ni = 1'b1;
    endtask

    initial begin
        bit lz, en, wr;
        logic [15:0] r, d;
        model_reset();
        #12;
        check("init_an", an_o, 4'hF);
        check("init_seg", seg_o, 7'h7F);
        check("init_fd", frame_done_o, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        cyc(0, 1, 0, 16'h1234);
        repeat (70) cyc(1, 0, 0, 16'h0);
        cyc(1, 1, 0, 16'hABCD);
        repeat (70) cyc(1, 0, 0, 16'h0);
        cyc(0, 1, 1, 16'h0040);
        repeat (40) cyc(1, 0, 1, 16'h0);
        cyc(0, 1, 1, 16'h0000);
        repeat (40) cyc(1, 0, 1, 16'h0);
        repeat (5) cyc(1, 0, 0, 16'h0);
        async_reset();
        lz = 0;
        for (int i = 0; i < 2500; i++) begin
            en = ($urandom % 150) != 0;
            r = 16'($urandom);
            d = r >> (4 * $urandom_range(0, 4));
            wr = (run && en && (p % F == F - 1)) ? bit'($urandom % 2) : (($urandom % 30) == 0);
            if ($urandom % 60 == 0) lz = !lz;
            cyc(en, wr, lz, d);
            if ($urandom % 800 == 0) async_reset();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
